// File: rtl/shift_tx_arbiter_pkg.sv
// Shared definitions for the two-requester serializer: FSM encoding and requester ids.
package shift_tx_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // The requester that gets priority on the next tie, given the one just served.
    function automatic logic other_req(input logic id);
        return (id == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/shift_tx_datapath.sv
// WIDTH-bit loadable left-shift register; the MSB is the serial output bit.
module shift_tx_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] shreg;

    // NOTE: state is assigned with <= so every register samples pre-edge values;
    // blocking assignments here would make the result depend on process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= load_data;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/shift_tx_arbiter.sv
// Round-robin arbiter in front of a shared MSB-first serializer with valid/ready on both sides.
module shift_tx_arbiter
    import shift_tx_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic             grant_id,
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             pointer;
    logic             winner;
    logic             load;
    logic             shift;
    logic             last_bit;
    logic             msb;
    logic [WIDTH-1:0] winner_data;

    // A tie goes to the pointer; a lone requester always wins regardless of it.
    assign winner      = (req0_valid && req1_valid) ? pointer
                       : (req1_valid ? REQ1 : REQ0);
    assign winner_data = (winner == REQ1) ? req1_data : req0_data;
    assign last_bit    = (count == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            pointer  <= REQ0;
            grant_id <= REQ0;
            done     <= 1'b0;
        end else begin
            state <= next_state;
            done  <= shift && last_bit;
            if (load) begin
                grant_id <= winner;
                pointer  <= other_req(winner);
                count    <= '0;
            end else if (shift) begin
                count <= last_bit ? '0 : count + 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && (req0_valid || req1_valid)) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                    req0_ready = (winner == REQ0);
                    req1_ready = (winner == REQ1);
                end
            end
            SHIFT: begin
                if (sout_ready) begin
                    shift = 1'b1;
                    if (last_bit) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    shift_tx_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .load_data(winner_data),
        .msb      (msb)
    );

    // Serial outputs are gated by state so they read 0 whenever nothing is being shifted.
    assign busy       = (state == SHIFT);
    assign sout_valid = busy;
    assign sout       = busy && msb;
    assign sout_last  = busy && last_bit;

endmodule

// File: tb/tb_shift_tx_arbiter.sv
// Directed bench for shift_tx_arbiter with WIDTH=8 and hand-computed expected bit streams.
module tb_shift_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       sout;
    logic       sout_valid;
    logic       sout_ready;
    logic       sout_last;
    logic       grant_id;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;

    logic       late_en = 1'b0;
    logic [7:0] late_data = 8'h00;

    shift_tx_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .sout      (sout),
        .sout_valid(sout_valid),
        .sout_ready(sout_ready),
        .sout_last (sout_last),
        .grant_id  (grant_id),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_bit({tag, "_sout"},       sout,       1'b0);
        check_bit({tag, "_sout_valid"}, sout_valid, 1'b0);
        check_bit({tag, "_sout_last"},  sout_last,  1'b0);
        check_bit({tag, "_grant_id"},   grant_id,   1'b0);
        check_bit({tag, "_busy"},       busy,       1'b0);
        check_bit({tag, "_done"},       done,       1'b0);
    endtask

    // Called in the cycle right after an accept; returns in the done cycle.
    task automatic shift_word(input logic [7:0] w, input logic gid,
                              input int stall_at, input int stall_len, input string tag);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                sout_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check_bit($sformatf("%s_hold_bit%0d", tag, i),   sout,       w[7-i]);
                    check_bit($sformatf("%s_hold_last%0d", tag, i),  sout_last,  (i == 7));
                    check_bit($sformatf("%s_hold_valid%0d", tag, i), sout_valid, 1'b1);
                    tick();
                end
                sout_ready = 1'b1;
            end
            if (late_en && i == 4) begin
                req1_data = late_data;
                late_en   = 1'b0;
                #1;
            end
            check_bit($sformatf("%s_valid%0d", tag, i), sout_valid, 1'b1);
            check_bit($sformatf("%s_bit%0d", tag, i),   sout,       w[7-i]);
            check_bit($sformatf("%s_last%0d", tag, i),  sout_last,  (i == 7));
            check_bit($sformatf("%s_gid%0d", tag, i),   grant_id,   gid);
            check_bit($sformatf("%s_busy%0d", tag, i),  busy,       1'b1);
            check_bit($sformatf("%s_r0_%0d", tag, i),   req0_ready, 1'b0);
            check_bit($sformatf("%s_r1_%0d", tag, i),   req1_ready, 1'b0);
            check_bit($sformatf("%s_nodone%0d", tag, i), done,      1'b0);
            tick();
        end
        check_bit({tag, "_done"},        done,       1'b1);
        check_bit({tag, "_bubble_valid"}, sout_valid, 1'b0);
        check_bit({tag, "_bubble_busy"},  busy,       1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        sout_ready = 1'b1;
        tick();
        tick();

        // Reset state, and readies held low by reset even with a valid present.
        check_idle_outputs("reset");
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_bit("reset_r0_forced", req0_ready, 1'b0);
        check_bit("reset_r1_forced", req1_ready, 1'b0);
        req1_valid = 1'b0;

        // Single word, no stall.
        reset     = 1'b0;
        req0_data = 8'hA5;
        #1;
        check_bit("single_r0", req0_ready, 1'b1);
        check_bit("single_r1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        shift_word(8'hA5, 1'b0, -1, 0, "single");
        tick();
        check_bit("single_done_pulse", done, 1'b0);

        // Reset returns the pointer to requester 0 before the fairness run.
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Contention: both valid throughout, grants alternate 0,1,0,1.
        req0_valid = 1'b1;
        req0_data  = 8'hF0;
        req1_valid = 1'b1;
        req1_data  = 8'h0F;
        #1;
        check_bit("fair0_r0", req0_ready, 1'b1);
        check_bit("fair0_r1", req1_ready, 1'b0);
        tick();
        shift_word(8'hF0, 1'b0, -1, 0, "fair0");
        check_bit("fair1_r0", req0_ready, 1'b0);
        check_bit("fair1_r1", req1_ready, 1'b1);
        tick();
        shift_word(8'h0F, 1'b1, -1, 0, "fair1");
        check_bit("fair2_r0", req0_ready, 1'b1);
        check_bit("fair2_r1", req1_ready, 1'b0);
        tick();
        shift_word(8'hF0, 1'b0, -1, 0, "fair2");
        check_bit("fair3_r0", req0_ready, 1'b0);
        check_bit("fair3_r1", req1_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        shift_word(8'h0F, 1'b1, -1, 0, "fair3");
        tick();

        // Backpressure: three stalled cycles after the third bit.
        req0_valid = 1'b1;
        req0_data  = 8'h81;
        #1;
        check_bit("bp_r0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        shift_word(8'h81, 1'b0, 3, 3, "bp");
        tick();

        // Reset mid-word after four bits of 8'hFF.
        req0_valid = 1'b1;
        req0_data  = 8'hFF;
        #1;
        check_bit("rst_mid_r0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_bit($sformatf("rst_mid_bit%0d", i), sout, 1'b1);
            tick();
        end
        reset = 1'b1;
        tick();
        check_idle_outputs("rst_mid");
        reset = 1'b0;
        tick();
        check_bit("rst_mid_no_done", done, 1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_bit("rst_ptr_r0", req0_ready, 1'b1);
        check_bit("rst_ptr_r1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_data  = 8'h5A;
        #1;
        check_bit("rst_fresh_r1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        shift_word(8'h5A, 1'b1, -1, 0, "rst_fresh");
        tick();

        // Ready discipline: req1 waits through a req0 word and its data changes meanwhile.
        req0_valid = 1'b1;
        req0_data  = 8'h33;
        #1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 8'h11;
        late_en    = 1'b1;
        late_data  = 8'hC3;
        shift_word(8'h33, 1'b0, -1, 0, "wait");
        check_bit("wait_r1_accept", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        shift_word(8'hC3, 1'b1, -1, 0, "late");

        // Single requester repeating three words.
        req1_valid = 1'b1;
        req1_data  = 8'h01;
        #1;
        check_bit("rep0_r1", req1_ready, 1'b1);
        tick();
        shift_word(8'h01, 1'b1, -1, 0, "rep0");
        req1_data = 8'h80;
        #1;
        check_bit("rep1_r1", req1_ready, 1'b1);
        tick();
        shift_word(8'h80, 1'b1, -1, 0, "rep1");
        req1_data = 8'h3C;
        #1;
        check_bit("rep2_r1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        shift_word(8'h3C, 1'b1, -1, 0, "rep2");
        tick();
        check_bit("end_idle_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
